// File: rtl/vga_pkg.sv
// Shared timing defaults, widths and the 3-to-8 bit colour expansion
// used by the VGA scan-out path.
package vga_pkg;

    localparam int H_VIS_D  = 640;
    localparam int H_FP_D   = 16;
    localparam int H_SYNC_D = 96;
    localparam int H_BP_D   = 48;
    localparam int V_VIS_D  = 480;
    localparam int V_FP_D   = 10;
    localparam int V_SYNC_D = 2;
    localparam int V_BP_D   = 33;

    localparam int H_TOT    = H_VIS_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOT    = V_VIS_D + V_FP_D + V_SYNC_D + V_BP_D;
    localparam int HS_START = H_VIS_D + H_FP_D;
    localparam int HS_END   = HS_START + H_SYNC_D - 1;
    localparam int VS_START = V_VIS_D + V_FP_D;
    localparam int VS_END   = VS_START + V_SYNC_D - 1;

    localparam int PIX_W  = 9;
    localparam int ADDR_W = 19;
    localparam int CNT_W  = 10;

    // Bit replication keeps 0 -> 0x00 and 7 -> 0xFF exact.
    function automatic logic [7:0] expand3to8(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

endpackage

// File: rtl/vga_scan_out_if.sv
// Video-memory read port plus VGA output pins; master is the scan-out
// engine, slave is the memory/display side.
interface vga_scan_out_if;
    import vga_pkg::*;

    logic              pix_en;
    logic [ADDR_W-1:0] raddr;
    logic [PIX_W-1:0]  rdata;
    logic [7:0]        VGA_R;
    logic [7:0]        VGA_G;
    logic [7:0]        VGA_B;
    logic              VGA_HS;
    logic              VGA_VS;
    logic              VGA_BLANK_N;
    logic              VGA_SYNC_N;
    logic              frame_start;

    modport master (
        input  pix_en, rdata,
        output raddr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, frame_start
    );

    modport slave (
        output pix_en, rdata,
        input  raddr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// Pixel/line counters advanced by pix_en, with visible/sync decode of the
// current position and look-ahead flags describing the position being entered.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VIS_D,
    parameter int H_FP   = H_FP_D,
    parameter int H_SYNC = H_SYNC_D,
    parameter int H_BP   = H_BP_D,
    parameter int V_VIS  = V_VIS_D,
    parameter int V_FP   = V_FP_D,
    parameter int V_SYNC = V_SYNC_D,
    parameter int V_BP   = V_BP_D
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_pix_en,
    output logic o_visible,
    output logic o_hs_n,
    output logic o_vs_n,
    output logic o_adv_visible,
    output logic o_adv_origin,
    output logic o_frame_start
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic [CNT_W-1:0] w_hnext;
    logic [CNT_W-1:0] w_vnext;
    logic             r_frame_start;

    always_comb begin
        w_hnext = (r_hcnt == H_LAST) ? '0 : r_hcnt + 1'b1;
        w_vnext = r_vcnt;
        if (r_hcnt == H_LAST) begin
            w_vnext = (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
        end
    end

    assign o_visible     = (r_hcnt < H_VIS_C) && (r_vcnt < V_VIS_C);
    assign o_hs_n        = !((r_hcnt >= HS_LO) && (r_hcnt <= HS_HI));
    assign o_vs_n        = !((r_vcnt >= VS_LO) && (r_vcnt <= VS_HI));
    assign o_adv_visible = i_pix_en && (w_hnext < H_VIS_C) && (w_vnext < V_VIS_C);
    assign o_adv_origin  = i_pix_en && (w_hnext == '0) && (w_vnext == '0);
    assign o_frame_start = r_frame_start;

    // Reset parks the counters at (0,0) without flagging a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= o_adv_origin;
            if (i_pix_en) begin
                r_hcnt <= w_hnext;
                r_vcnt <= w_vnext;
            end
        end
    end

endmodule

// File: rtl/vga_scan_out.sv
// Scans the frame buffer in raster order and drives the VGA port; colour,
// sync and blank all leave through the same one-tick output stage.
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VIS_D,
    parameter int H_FP   = H_FP_D,
    parameter int H_SYNC = H_SYNC_D,
    parameter int H_BP   = H_BP_D,
    parameter int V_VIS  = V_VIS_D,
    parameter int V_FP   = V_FP_D,
    parameter int V_SYNC = V_SYNC_D,
    parameter int V_BP   = V_BP_D
)
(
    input  logic           clk,
    input  logic           rst,
    vga_scan_out_if.master bus
);

    logic              w_visible;
    logic              w_hs_n;
    logic              w_vs_n;
    logic              w_adv_visible;
    logic              w_adv_origin;
    logic              w_frame_start;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_r_p1;
    logic [7:0]        r_g_p1;
    logic [7:0]        r_b_p1;
    logic              r_hs_n_p1;
    logic              r_vs_n_p1;
    logic              r_vld_p1;

    vga_timing #(
        .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .i_pix_en      (bus.pix_en),
        .o_visible     (w_visible),
        .o_hs_n        (w_hs_n),
        .o_vs_n        (w_vs_n),
        .o_adv_visible (w_adv_visible),
        .o_adv_origin  (w_adv_origin),
        .o_frame_start (w_frame_start)
    );

    // Address tracks the counters one-for-one with no multiply: it steps only
    // when entering a visible pixel, so blanking intervals hold the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raddr <= '0;
        end else if (w_adv_origin) begin
            r_raddr <= '0;
        end else if (w_adv_visible) begin
            r_raddr <= r_raddr + 1'b1;
        end
    end

    // Stage p1: rdata for the position being left is valid now, so colour
    // and the decode of that same position are captured together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r_p1    <= '0;
            r_g_p1    <= '0;
            r_b_p1    <= '0;
            r_hs_n_p1 <= 1'b1;
            r_vs_n_p1 <= 1'b1;
            r_vld_p1  <= 1'b0;
        end else if (bus.pix_en) begin
            r_r_p1    <= w_visible ? expand3to8(bus.rdata[8:6]) : 8'h00;
            r_g_p1    <= w_visible ? expand3to8(bus.rdata[5:3]) : 8'h00;
            r_b_p1    <= w_visible ? expand3to8(bus.rdata[2:0]) : 8'h00;
            r_hs_n_p1 <= w_hs_n;
            r_vs_n_p1 <= w_vs_n;
            r_vld_p1  <= w_visible;
        end
    end

    assign bus.raddr       = r_raddr;
    assign bus.VGA_R       = r_r_p1;
    assign bus.VGA_G       = r_g_p1;
    assign bus.VGA_B       = r_b_p1;
    assign bus.VGA_HS      = r_hs_n_p1;
    assign bus.VGA_VS      = r_vs_n_p1;
    assign bus.VGA_BLANK_N = r_vld_p1;
    assign bus.VGA_SYNC_N  = 1'b0;
    assign bus.frame_start = w_frame_start;

endmodule
